core_clk_rst_ctrl: RTL and testbench

Parametrised core clock and reset sequencer placed between the test controller and the processor under test. It replaces the fixed divide-by-2 toggle with four capabilities:
- programmable divide ratio
- free-run and stop modes
- N-edge pulse (single-step) mode
- a counted reset sequence

It is driven by a small valid/ready command port from the controller.

---
 rtl/core_clk_rst_ctrl_pkg.sv | 40 ++++
 rtl/core_clk_rst_ctrl_clk_div_gen.sv | 52 +++++
 rtl/core_clk_rst_ctrl.sv | 170 +++++++++++++++++
 tb/tb_core_clk_rst_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_clk_rst_ctrl_pkg.sv
// core_clk_pkg: shared types for the core clock/reset sequencer.
//   CMD_*     : command opcode encodings on cmd_op_i
//   cmd_op_e  : 3-bit command enum (6 and 7 decode as no-ops)
//   state_e   : sequencer states
//   is_idle() : states in which commands are accepted
package core_clk_pkg;

    localparam logic [2:0] CMD_NOP        = 3'd0;
    localparam logic [2:0] CMD_SET_DIV    = 3'd1;
    localparam logic [2:0] CMD_RUN        = 3'd2;
    localparam logic [2:0] CMD_STOP       = 3'd3;
    localparam logic [2:0] CMD_PULSE      = 3'd4;
    localparam logic [2:0] CMD_RESET_CORE = 3'd5;
    localparam logic [2:0] CMD_RSVD6      = 3'd6;
    localparam logic [2:0] CMD_RSVD7      = 3'd7;

    typedef enum logic [2:0] {
        OP_NOP        = CMD_NOP,
        OP_SET_DIV    = CMD_SET_DIV,
        OP_RUN        = CMD_RUN,
        OP_STOP       = CMD_STOP,
        OP_PULSE      = CMD_PULSE,
        OP_RESET_CORE = CMD_RESET_CORE,
        OP_RSVD6      = CMD_RSVD6,
        OP_RSVD7      = CMD_RSVD7
    } cmd_op_e;

    typedef enum logic [2:0] {
        RESETTING,
        STOPPED,
        RUNNING,
        PULSING,
        STOPPING
    } state_e;

    function automatic logic is_idle(input state_e s);
        return (s == STOPPED) || (s == RUNNING);
    endfunction

endpackage

// File: rtl/core_clk_rst_ctrl_clk_div_gen.sv
// clk_div_gen: programmable half-period divider for the core clock.
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : divider runs when high; when low, clock and counter held at 0
//   div        : half-period minus one, in clk cycles
//   clk_core   : registered divided clock
//   core_rise  : registered strobe, high in the first cycle clk_core is 1
//   low_phase  : clk_core is currently low
//   rise_next  : clk_core rises at the coming clk edge
//   fall_next  : clk_core falls at the coming clk edge
module clk_div_gen #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 clk_core,
    output logic                 core_rise,
    output logic                 low_phase,
    output logic                 rise_next,
    output logic                 fall_next
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 terminal;

    // >= rather than == so that lowering div mid-phase toggles on the next clk
    assign terminal  = en && (cnt >= div);
    assign rise_next = terminal && !clk_core;
    assign fall_next = terminal && clk_core;
    assign low_phase = !clk_core;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            clk_core  <= 1'b0;
            core_rise <= 1'b0;
        end else if (!en) begin
            cnt       <= '0;
            clk_core  <= 1'b0;
            core_rise <= 1'b0;
        end else if (cnt >= div) begin
            cnt       <= '0;
            clk_core  <= ~clk_core;
            core_rise <= ~clk_core;
        end else begin
            cnt       <= cnt + 1'b1;
            core_rise <= 1'b0;
        end
    end

endmodule

// File: rtl/core_clk_rst_ctrl.sv
// core_clk_rst_ctrl: core clock and reset sequencer driven by a valid/ready
// command port (NOP, SET_DIV, RUN, STOP, PULSE, RESET_CORE).
//   clk, rst_n   : system clock, synchronous active-low reset
//   cmd_valid_i  : command valid; accepted when cmd_ready_o is also high
//   cmd_ready_o  : high in STOPPED and RUNNING
//   cmd_op_i     : command opcode
//   cmd_arg_i    : divide value (low DIV_WIDTH bits) or pulse count
//   clk_core_o   : divided core clock
//   core_rise_o  : one-cycle strobe with each core clock rising edge
//   rst_core_o   : active-high core reset
//   busy_o       : high in RESETTING, PULSING, STOPPING
//   done_o       : one-cycle strobe at the end of PULSE, STOP, RESET_CORE
module core_clk_rst_ctrl
    import core_clk_pkg::*;
#(
    parameter int unsigned DIV_WIDTH          = 16,
    parameter int unsigned PULSE_CONTROL_BITS = 32,
    parameter int unsigned RESET_CLK_CYCLES   = 20,
    parameter int unsigned DEFAULT_DIV        = 0,
    parameter int unsigned AUTO_RUN           = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [2:0]                    cmd_op_i,
    input  logic [PULSE_CONTROL_BITS-1:0] cmd_arg_i,
    output logic                          clk_core_o,
    output logic                          core_rise_o,
    output logic                          rst_core_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam logic [PULSE_CONTROL_BITS-1:0] RESET_EDGES = PULSE_CONTROL_BITS'(RESET_CLK_CYCLES);
    localparam logic [DIV_WIDTH-1:0]          DIV_INIT    = DIV_WIDTH'(DEFAULT_DIV);

    state_e                        state;
    cmd_op_e                       op;
    logic [DIV_WIDTH-1:0]          div;
    logic [PULSE_CONTROL_BITS-1:0] edge_cnt;
    logic [PULSE_CONTROL_BITS-1:0] edge_inc;
    logic [PULSE_CONTROL_BITS-1:0] pulse_n;
    logic                          por;
    logic                          ready;
    logic                          busy;
    logic                          rst_core;
    logic                          done;
    logic                          accept;
    logic                          stop_req;
    logic                          clk_after;
    logic                          low_phase;
    logic                          rise_next;
    logic                          fall_next;

    clk_div_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state != STOPPED),
        .div       (div),
        .clk_core  (clk_core_o),
        .core_rise (core_rise_o),
        .low_phase (low_phase),
        .rise_next (rise_next),
        .fall_next (fall_next)
    );

    assign op       = cmd_op_e'(cmd_op_i);
    assign accept   = cmd_valid_i && ready;
    assign edge_inc = (&edge_cnt) ? edge_cnt : edge_cnt + 1'b1;
    // PULSE 0 is handled exactly like STOP in both idle states
    assign stop_req = (op == OP_STOP) || ((op == OP_PULSE) && (cmd_arg_i == '0));
    // Core clock level after the coming edge; a stop decided on a high level
    // must drain through STOPPING so the high phase is never cut short.
    assign clk_after = rise_next || (!low_phase && !fall_next);

    assign cmd_ready_o = ready;
    assign busy_o      = busy;
    assign rst_core_o  = rst_core;
    assign done_o      = done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RESETTING;
            div      <= DIV_INIT;
            edge_cnt <= '0;
            pulse_n  <= '0;
            por      <= 1'b1;
            ready    <= 1'b0;
            busy     <= 1'b1;
            rst_core <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RESETTING: begin
                    if (rise_next) begin
                        edge_cnt <= edge_inc;
                    end else if (fall_next && (edge_cnt >= RESET_EDGES)) begin
                        rst_core <= 1'b0;
                        done     <= !por;
                        por      <= 1'b0;
                        state    <= (por && (AUTO_RUN != 0)) ? RUNNING : STOPPED;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                STOPPED, RUNNING: begin
                    if (accept) begin
                        if (op == OP_SET_DIV) begin
                            div <= cmd_arg_i[DIV_WIDTH-1:0];
                        end else if (op == OP_RUN) begin
                            state <= RUNNING;
                        end else if (stop_req) begin
                            if (state == RUNNING && clk_after) begin
                                state <= STOPPING;
                                ready <= 1'b0;
                                busy  <= 1'b1;
                            end else begin
                                state <= STOPPED;
                                done  <= 1'b1;
                            end
                        end else if (op == OP_PULSE) begin
                            state    <= PULSING;
                            pulse_n  <= cmd_arg_i;
                            edge_cnt <= '0;
                            ready    <= 1'b0;
                            busy     <= 1'b1;
                        end else if (op == OP_RESET_CORE) begin
                            state    <= RESETTING;
                            rst_core <= 1'b1;
                            edge_cnt <= '0;
                            ready    <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end

                PULSING: begin
                    if (rise_next) begin
                        edge_cnt <= edge_inc;
                        // pulse_n >= 1 here; this rise is the last one requested
                        if (edge_cnt >= pulse_n - 1'b1) begin
                            state <= STOPPING;
                        end
                    end
                end

                STOPPING: begin
                    if (fall_next) begin
                        state <= STOPPED;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= RESETTING;
                    ready <= is_idle(RESETTING);
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_clk_rst_ctrl.sv
// Self-checking bench for core_clk_rst_ctrl (DEFAULT_DIV=0, RESET_CLK_CYCLES=4,
// AUTO_RUN=0). Directed scenarios plus a randomized command stream compared
// every cycle against a behavioural model kept in this file.
module tb_core_clk_rst_ctrl;

    localparam int DW   = 16;
    localparam int PW   = 32;
    localparam int RCC  = 4;
    localparam int DDIV = 0;
    localparam int AR   = 0;

    localparam int M_SEQ   = 0;
    localparam int M_IDLE  = 1;
    localparam int M_FREE  = 2;
    localparam int M_PULSE = 3;
    localparam int M_DRAIN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_op = 3'd0;
    logic [PW-1:0] cmd_arg = '0;
    logic          cmd_ready, clk_core, core_rise, rst_core, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    longint unsigned cyc = 0, m_start = 0, m_div = 0, m_rises = 0, m_target = 0;
    bit m_clk, m_rise, m_rst, m_done, m_ready, m_busy, m_por;
    int m_mode;

    core_clk_rst_ctrl #(
        .DIV_WIDTH          (DW),
        .PULSE_CONTROL_BITS (PW),
        .RESET_CLK_CYCLES   (RCC),
        .DEFAULT_DIV        (DDIV),
        .AUTO_RUN           (AR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_arg_i   (cmd_arg),
        .clk_core_o  (clk_core),
        .core_rise_o (core_rise),
        .rst_core_o  (rst_core),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // One clk edge of the reference model, using the inputs seen at that edge.
    // The core clock is described by the edge index at which its current phase
    // began: a phase lasts until more than div edges have elapsed.
    task automatic model_step();
        bit run, tog, rising, falling, acc;
        cyc++;
        if (!rst_n) begin
            m_clk = 0; m_rise = 0; m_rst = 1; m_done = 0; m_ready = 0; m_busy = 1;
            m_mode = M_SEQ; m_div = DDIV; m_start = cyc; m_rises = 0; m_por = 1;
            return;
        end
        run     = (m_mode != M_IDLE);
        tog     = run && ((cyc - m_start) > m_div);
        rising  = tog && !m_clk;
        falling = tog && m_clk;
        if (tog) begin m_clk = !m_clk; m_start = cyc; end
        if (!run) begin m_clk = 0; m_start = cyc; end
        m_rise = rising;
        m_done = 0;
        acc = cmd_valid && m_ready;
        case (m_mode)
            M_SEQ: begin
                if (rising) begin
                    if (m_rises < 64'hFFFF_FFFF) m_rises++;
                end else if (falling && m_rises >= RCC) begin
                    m_rst = 0; m_done = !m_por;
                    m_mode = (m_por && AR != 0) ? M_FREE : M_IDLE;
                    m_por = 0;
                end
            end
            M_PULSE: if (rising) begin
                m_rises++;
                if (m_rises >= m_target) m_mode = M_DRAIN;
            end
            M_DRAIN: if (falling) begin m_mode = M_IDLE; m_done = 1; end
            default: if (acc) begin
                if (cmd_op == 3'd1) m_div = cmd_arg[DW-1:0];
                else if (cmd_op == 3'd2) m_mode = M_FREE;
                else if (cmd_op == 3'd3 || (cmd_op == 3'd4 && cmd_arg == 0)) begin
                    // clock level after this edge decides whether it must drain
                    if (m_mode == M_FREE && m_clk) m_mode = M_DRAIN;
                    else begin m_mode = M_IDLE; m_done = 1; end
                end else if (cmd_op == 3'd4) begin
                    m_mode = M_PULSE; m_target = cmd_arg; m_rises = 0;
                end else if (cmd_op == 3'd5) begin
                    m_mode = M_SEQ; m_rst = 1; m_rises = 0;
                end
            end
        endcase
        m_ready = (m_mode == M_IDLE) || (m_mode == M_FREE);
        m_busy  = !m_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [PW-1:0] arg);
        int w = 0;
        while (!cmd_ready && w < 200) begin tick(); w++; end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout op=%0d ready=%b required 1", op, cmd_ready);
        end
        cmd_valid = 1; cmd_op = op; cmd_arg = arg;
        tick();
        cmd_valid = 0; cmd_op = 0; cmd_arg = '0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst_n = 0;
        tick(); tick();
        obs = {clk_core, core_rise, rst_core, done, cmd_ready, busy};
        n_checks++;
        if (obs !== 6'b001001) begin
            n_fail++; $display("FAIL reset_values got=%b exp=001001", obs);
        end
    endtask

    task automatic test_power_on();
        bit bad_done = 0, bad_clk = 0;
        rst_n = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (clk_core !== i[0] || core_rise !== i[0]) begin
                n_fail++; $display("FAIL por_toggle i=%0d clk=%b rise=%b exp=%b", i, clk_core, core_rise, i[0]);
            end
            n_checks++;
            if (rst_core !== (i < 8)) begin
                n_fail++; $display("FAIL por_rst_core i=%0d got=%b exp=%b", i, rst_core, (i < 8));
            end
            if (done !== 0) bad_done = 1;
        end
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL por_idle ready/busy got=%b exp=10", {cmd_ready, busy});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done !== 0) bad_done = 1;
            if (clk_core !== 0) bad_clk = 1;
        end
        n_checks++;
        if (bad_done || bad_clk) begin
            n_fail++; $display("FAIL por_stopped done_seen=%b clk_moved=%b exp 0 0", bad_done, bad_clk);
        end
    endtask

    task automatic test_run_div3();
        send(3'd1, 3);
        send(3'd2, 0);
        for (int i = 1; i <= 40; i++) begin
            bit eclk, erise;
            tick();
            eclk  = (i >= 4) && (((i - 4) / 4) % 2 == 0);
            erise = (i >= 4) && ((i - 4) % 8 == 0);
            n_checks++;
            if (clk_core !== eclk || core_rise !== erise) begin
                n_fail++;
                $display("FAIL run_div3 i=%0d clk=%b rise=%b exp clk=%b rise=%b", i, clk_core, core_rise, eclk, erise);
            end
        end
        send(3'd3, 0);
    endtask

    task automatic test_pulse5();
        int rises = 0, dones = 0, done_at = -1;
        bit busy_gap = 0;
        send(3'd1, 1);
        send(3'd4, 5);
        n_checks++;
        if (busy !== 1) begin n_fail++; $display("FAIL pulse5_busy_start got=%b exp=1", busy); end
        for (int i = 1; i <= 30; i++) begin
            bit erise;
            tick();
            erise = (i >= 2) && (i <= 18) && ((i - 2) % 4 == 0);
            n_checks++;
            if (core_rise !== erise) begin
                n_fail++; $display("FAIL pulse5_rise i=%0d got=%b exp=%b", i, core_rise, erise);
            end
            if (core_rise) rises++;
            if (done) begin dones++; done_at = i; end
            if (i < 20 && busy !== 1) busy_gap = 1;
            if (i == 20) begin
                n_checks++;
                if ({done, clk_core, busy} !== 3'b100) begin
                    n_fail++; $display("FAIL pulse5_end done/clk/busy got=%b exp=100", {done, clk_core, busy});
                end
            end
        end
        n_checks++;
        if (rises != 5 || dones != 1 || done_at != 20 || busy_gap) begin
            n_fail++;
            $display("FAIL pulse5_summary rises=%0d dones=%0d done_at=%0d busy_gap=%b exp 5 1 20 0", rises, dones, done_at, busy_gap);
        end
    endtask

    task automatic test_stop_high();
        int w = 0, high = 1;
        send(3'd1, 2);
        send(3'd2, 0);
        while (!core_rise && w < 20) begin tick(); w++; end
        n_checks++;
        if (!core_rise) begin n_fail++; $display("FAIL stop_wait_rise got=%b exp=1", core_rise); end
        cmd_valid = 1; cmd_op = 3'd3;
        tick();
        cmd_valid = 0; cmd_op = 0;
        if (clk_core) high++;
        n_checks++;
        if ({clk_core, cmd_ready, busy, done} !== 4'b1010) begin
            n_fail++; $display("FAIL stop_accept clk/ready/busy/done got=%b exp=1010", {clk_core, cmd_ready, busy, done});
        end
        tick();
        if (clk_core) high++;
        n_checks++;
        if ({cmd_ready, done} !== 2'b00) begin
            n_fail++; $display("FAIL stop_hold ready/done got=%b exp=00", {cmd_ready, done});
        end
        tick();
        n_checks++;
        if ({clk_core, done, cmd_ready, busy} !== 4'b0110 || high != 3) begin
            n_fail++;
            $display("FAIL stop_end clk/done/ready/busy got=%b exp=0110 high=%0d exp=3", {clk_core, done, cmd_ready, busy}, high);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (clk_core !== 0 || done !== 0) begin
                n_fail++; $display("FAIL stop_quiet i=%0d clk=%b done=%b exp 0 0", i, clk_core, done);
            end
        end
    endtask

    task automatic test_pulse0_and_busy();
        int rises = 0, done_at = -1;
        send(3'd1, 0);
        send(3'd4, 0);
        n_checks++;
        if ({done, clk_core} !== 2'b10) begin
            n_fail++; $display("FAIL pulse0_done done/clk got=%b exp=10", {done, clk_core});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({done, clk_core, core_rise} !== 3'b000) begin
                n_fail++; $display("FAIL pulse0_quiet i=%0d done/clk/rise got=%b exp=000", i, {done, clk_core, core_rise});
            end
        end
        send(3'd4, 3);
        for (int i = 1; i <= 10; i++) begin
            if (busy) begin
                cmd_valid = 1;
                case ($urandom_range(0, 3))
                    0: begin cmd_op = 3'd1; cmd_arg = 7; end
                    1: cmd_op = 3'd2;
                    2: cmd_op = 3'd3;
                    default: cmd_op = 3'd5;
                endcase
            end else begin
                cmd_valid = 0; cmd_op = 0; cmd_arg = '0;
            end
            tick();
            if (core_rise) rises++;
            if (done && done_at < 0) done_at = i;
        end
        cmd_valid = 0; cmd_op = 0; cmd_arg = '0;
        n_checks++;
        if (rises != 3 || done_at != 6 || clk_core !== 0 || rst_core !== 0) begin
            n_fail++;
            $display("FAIL busy_ignore rises=%0d done_at=%0d clk=%b rst=%b exp 3 6 0 0", rises, done_at, clk_core, rst_core);
        end
        send(3'd4, 1);
        tick();
        n_checks++;
        if (core_rise !== 1) begin n_fail++; $display("FAIL div_unchanged rise got=%b exp=1", core_rise); end
        tick(); tick();
    endtask

    task automatic test_rst_mid_pulse();
        logic [5:0] obs;
        send(3'd4, 100);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 0;
        tick();
        obs = {clk_core, core_rise, rst_core, done, cmd_ready, busy};
        n_checks++;
        if (obs !== 6'b001001) begin n_fail++; $display("FAIL rst_mid_values got=%b exp=001001", obs); end
        rst_n = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i >= 7) begin
                n_checks++;
                if (rst_core !== (i == 7) || done !== 0) begin
                    n_fail++; $display("FAIL rst_mid_restart i=%0d rst=%b done=%b exp rst=%b done=0", i, rst_core, done, (i == 7));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] obs, exp;
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_arg   = (cmd_op == 3'd1) ? PW'($urandom_range(0, 3)) : PW'($urandom_range(0, 6));
            tick();
            obs = {clk_core, core_rise, rst_core, done, cmd_ready, busy};
            exp = {m_clk, m_rise, m_rst, m_done, m_ready, m_busy};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL random cycle=%0d clk/rise/rst/done/ready/busy got=%b exp=%b", i, obs, exp);
            end
        end
        rst_n = 1; cmd_valid = 0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_run_div3();
        test_pulse5();
        test_stop_high();
        test_pulse0_and_busy();
        test_rst_mid_pulse();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
